// File: rtl/sigmoid_arbiter.sv
// Round-robin arbiter sharing one in-order sigmoid pipeline among
// NUM_REQ requesters; results are routed back via an issue-order tag FIFO.
//
// Ports:
//   clk, rst_n      rising-edge clock, async active-low reset
//   req_valid/data  per-requester bf16 operands (16 bits each)
//   req_ready       one-hot grant, combinational
//   sig_valid_in    registered issue to the sigmoid pipeline
//   sig_data_in     registered issue operand
//   sig_valid_out   pipeline result strobe (in order, no backpressure)
//   sig_data_out    pipeline result
//   resp_valid      one-hot result strobe to the owner
//   resp_data       registered result
//   resp_id         registered owner index
//   inflight        issued but unreturned operation count
//   err             sticky: result arrived with no outstanding tag
module sigmoid_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int MAX_INFLIGHT = 8,
    parameter int ID_W         = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [16*NUM_REQ-1:0]         req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          sig_valid_in,
    output logic [15:0]                   sig_data_in,
    input  logic                          sig_valid_out,
    input  logic [15:0]                   sig_data_out,
    output logic [NUM_REQ-1:0]            resp_valid,
    output logic [15:0]                   resp_data,
    output logic [ID_W-1:0]               resp_id,
    output logic [$clog2(MAX_INFLIGHT):0] inflight,
    output logic                          err
);

    localparam int AW = $clog2(MAX_INFLIGHT);
    localparam int CW = AW + 1;

    logic [ID_W-1:0] ptr;
    logic [ID_W-1:0] gnt_idx;
    logic [ID_W-1:0] idx;
    logic            gnt_any;
    logic            full;
    logic            empty;
    logic            push;
    logic            pop;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [ID_W-1:0] tag_mem [MAX_INFLIGHT];

    assign full  = (inflight == CW'(MAX_INFLIGHT));
    assign empty = (inflight == '0);

    // First valid requester at or after ptr, wrapping.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        idx     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = ID_W'((int'(ptr) + k) % NUM_REQ);
            if (!gnt_any && req_valid[idx]) begin
                gnt_any = 1'b1;
                gnt_idx = idx;
            end
        end
    end

    // Full blocks issue even if a pop lands this cycle.
    always_comb begin
        req_ready = '0;
        if (rst_n && gnt_any && !full) begin
            req_ready[gnt_idx] = 1'b1;
        end
    end

    assign push = |req_ready;
    assign pop  = sig_valid_out && !empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr          <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            inflight     <= '0;
            err          <= 1'b0;
            sig_valid_in <= 1'b0;
            sig_data_in  <= '0;
            resp_valid   <= '0;
            resp_data    <= '0;
            resp_id      <= '0;
            for (int i = 0; i < MAX_INFLIGHT; i++) begin
                tag_mem[i] <= '0;
            end
        end else begin
            sig_valid_in <= push;
            if (push) begin
                sig_data_in      <= req_data[16*gnt_idx +: 16];
                tag_mem[wr_ptr]  <= gnt_idx;
                wr_ptr           <= wr_ptr + 1'b1;
                if (int'(gnt_idx) == NUM_REQ - 1) begin
                    ptr <= '0;
                end else begin
                    ptr <= gnt_idx + 1'b1;
                end
            end

            resp_valid <= '0;
            if (pop) begin
                resp_valid <= NUM_REQ'(1) << tag_mem[rd_ptr];
                resp_id    <= tag_mem[rd_ptr];
                resp_data  <= sig_data_out;
                rd_ptr     <= rd_ptr + 1'b1;
            end

            if (sig_valid_out && empty) begin
                err <= 1'b1;
            end

            case ({push, pop})
                2'b10:   inflight <= inflight + 1'b1;
                2'b01:   inflight <= inflight - 1'b1;
                default: inflight <= inflight;
            endcase
        end
    end

endmodule

// File: tb/tb_sigmoid_arbiter.sv
// Bench for sigmoid_arbiter: identity pipeline stub with selectable
// latency, queue-based reference model, and directed scenarios.
module tb_sigmoid_arbiter;

    localparam int N  = 4;
    localparam int MI = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [N-1:0]  req_valid = '0;
    logic [16*N-1:0] req_data = '0;
    logic [N-1:0]  req_ready;
    logic          sig_valid_in;
    logic [15:0]   sig_data_in;
    logic          sig_valid_out;
    logic [15:0]   sig_data_out;
    logic [N-1:0]  resp_valid;
    logic [15:0]   resp_data;
    logic [1:0]    resp_id;
    logic [3:0]    inflight;
    logic          err;

    always #5 clk = ~clk;

    sigmoid_arbiter #(
        .NUM_REQ(N),
        .MAX_INFLIGHT(MI)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req_valid(req_valid),
        .req_data(req_data),
        .req_ready(req_ready),
        .sig_valid_in(sig_valid_in),
        .sig_data_in(sig_data_in),
        .sig_valid_out(sig_valid_out),
        .sig_data_out(sig_data_out),
        .resp_valid(resp_valid),
        .resp_data(resp_data),
        .resp_id(resp_id),
        .inflight(inflight),
        .err(err)
    );

    // Identity pipeline stub, latency lat (1..16), reset with the DUT.
    int          lat = 5;
    logic        inj = 1'b0;
    logic        v_sh [16];
    logic [15:0] d_sh [16];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) begin
                v_sh[i] <= 1'b0;
                d_sh[i] <= '0;
            end
        end else begin
            v_sh[0] <= sig_valid_in;
            d_sh[0] <= sig_data_in;
            for (int i = 1; i < 16; i++) begin
                v_sh[i] <= v_sh[i-1];
                d_sh[i] <= d_sh[i-1];
            end
        end
    end

    assign sig_valid_out = v_sh[lat-1] | inj;
    assign sig_data_out  = d_sh[lat-1];

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [31:0] a,
                       input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
        end
    endtask

    // Reference model: round-robin pointer, tag queue, expected outputs.
    int          ptr_m = 0;
    int          q[$];
    logic        err_m = 1'b0;
    logic        exp_siv = 1'b0;
    logic [15:0] exp_sid = '0;
    logic [N-1:0] exp_rv = '0;
    logic [1:0]  exp_rid = '0;
    logic [15:0] exp_rdata = '0;

    always @(negedge clk) begin : cmp
        logic [N-1:0] er;
        int g;
        if (!rst_n) begin
            chk("rst_req_ready", req_ready, 0);
            chk("rst_sig_valid_in", sig_valid_in, 0);
            chk("rst_sig_data_in", sig_data_in, 0);
            chk("rst_resp_valid", resp_valid, 0);
            chk("rst_resp_data", resp_data, 0);
            chk("rst_resp_id", resp_id, 0);
            chk("rst_inflight", inflight, 0);
            chk("rst_err", err, 0);
            ptr_m = 0;
            q.delete();
            err_m = 1'b0;
            exp_siv = 1'b0;
            exp_sid = '0;
            exp_rv = '0;
            exp_rid = '0;
            exp_rdata = '0;
        end else begin
            er = '0;
            g = -1;
            if (q.size() < MI) begin
                for (int k = 0; k < N; k++) begin
                    int i;
                    i = (ptr_m + k) % N;
                    if (g < 0 && req_valid[i]) g = i;
                end
            end
            if (g >= 0) er[g] = 1'b1;
            chk("m_req_ready", req_ready, er);
            chk("m_sig_valid_in", sig_valid_in, exp_siv);
            chk("m_sig_data_in", sig_data_in, exp_sid);
            chk("m_resp_valid", resp_valid, exp_rv);
            chk("m_resp_id", resp_id, exp_rid);
            chk("m_resp_data", resp_data, exp_rdata);
            chk("m_inflight", inflight, q.size());
            chk("m_err", err, err_m);
            exp_rv = '0;
            if (sig_valid_out) begin
                if (q.size() == 0) begin
                    err_m = 1'b1;
                end else begin
                    exp_rv[q[0]] = 1'b1;
                    exp_rid = 2'(q[0]);
                    exp_rdata = sig_data_out;
                    void'(q.pop_front());
                end
            end
            exp_siv = (g >= 0);
            if (g >= 0) begin
                exp_sid = req_data[16*g +: 16];
                q.push_back(g);
                ptr_m = (g + 1) % N;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int l);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        lat = l;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        errors++;
        $display("FAIL watchdog: got timeout expected finish");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int ng;
        int peak;

        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single request: issue at T+1, response at T+7.
        tick();
        req_data[15:0] = 16'h3F80;
        req_valid = 4'b0001;
        @(negedge clk);
        chk("t1_ready", req_ready, 4'b0001);
        tick();
        req_valid = '0;
        @(negedge clk);
        chk("t1_siv", sig_valid_in, 1);
        chk("t1_sid", sig_data_in, 16'h3F80);
        repeat (5) tick();
        @(negedge clk);
        chk("t1_rv_early", resp_valid, 0);
        tick();
        @(negedge clk);
        chk("t1_rv", resp_valid, 4'b0001);
        chk("t1_rid", resp_id, 0);
        chk("t1_rdata", resp_data, 16'h3F80);

        // All requesters, continuous traffic.
        do_reset(5);
        for (int i = 0; i < N; i++) req_data[16*i +: 16] = 16'h4000 + 16'(i);
        req_valid = 4'hF;
        n = 0;
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            if (c < 12) chk("t2_grant", req_ready, 32'h1 << (c % 4));
            if (resp_valid != 0) begin
                chk("t2_rv", resp_valid, 32'h1 << (n % 4));
                chk("t2_rid", resp_id, n % 4);
                chk("t2_rdata", resp_data, 16'h4000 + 16'(n % 4));
                n++;
            end
            tick();
            if (c == 11) req_valid = '0;
        end
        chk("t2_nresp", n, 12);

        // Requesters 0 and 2 only, starting from ptr = 3.
        req_valid = 4'b0100;
        @(negedge clk);
        chk("t3_pre", req_ready, 4'b0100);
        tick();
        req_valid = 4'b0101;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("t3_grant", req_ready, (c % 2 == 0) ? 32'h1 : 32'h4);
            tick();
        end
        req_valid = '0;
        repeat (10) tick();

        // Long pipeline: in-flight limit.
        do_reset(12);
        req_valid = 4'hF;
        ng = 0;
        peak = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (c < 14 && req_ready != 0) ng++;
            if (c == 13) chk("t4_stall", req_ready, 0);
            if (c == 14) chk("t4_resume", req_ready != 0, 1);
            if (int'(inflight) > peak) peak = int'(inflight);
            tick();
        end
        chk("t4_grants", ng, 8);
        chk("t4_peak", peak, 8);
        req_valid = '0;
        repeat (40) tick();

        // Result with nothing outstanding.
        do_reset(5);
        inj = 1'b1;
        tick();
        inj = 1'b0;
        @(negedge clk);
        chk("t5_err", err, 1);
        chk("t5_rv", resp_valid, 0);
        tick();
        req_data[15:0] = 16'h3F80;
        req_valid = 4'b0001;
        tick();
        req_valid = '0;
        repeat (10) tick();
        @(negedge clk);
        chk("t5_err_sticky", err, 1);
        do_reset(5);
        @(negedge clk);
        chk("t5_err_clr", err, 0);

        // Reset with three operations in flight.
        tick();
        req_valid = 4'b0111;
        repeat (3) tick();
        chk("t6_inflight", inflight, 3);
        rst_n = 1'b0;
        @(negedge clk);
        chk("t6_rst_ready", req_ready, 0);
        chk("t6_rst_inflight", inflight, 0);
        chk("t6_rst_siv", sig_valid_in, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        req_data[15:0] = 16'h1234;
        req_valid = 4'b0001;
        @(negedge clk);
        chk("t6_ready", req_ready, 4'b0001);
        tick();
        req_valid = '0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (c == 7) begin
                chk("t6_rv", resp_valid, 4'b0001);
                chk("t6_rid", resp_id, 0);
                chk("t6_rdata", resp_data, 16'h1234);
            end else begin
                chk("t6_no_stale", resp_valid, 0);
            end
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
